// File: rtl/seg_display_driver_pkg.sv
// seg_display_driver_pkg: shared 7-segment constants, ghost FSM states and digit-select helper.
package seg_display_driver_pkg;

    localparam int NUM_DIGITS = 8;
    localparam int DP_BIT     = 7;

    localparam logic [7:0] SEG_0   = 8'hC0;
    localparam logic [7:0] SEG_1   = 8'hF9;
    localparam logic [7:0] SEG_2   = 8'hA4;
    localparam logic [7:0] SEG_3   = 8'hB0;
    localparam logic [7:0] SEG_4   = 8'h99;
    localparam logic [7:0] SEG_5   = 8'h92;
    localparam logic [7:0] SEG_6   = 8'h82;
    localparam logic [7:0] SEG_7   = 8'hF8;
    localparam logic [7:0] SEG_8   = 8'h80;
    localparam logic [7:0] SEG_9   = 8'h90;
    localparam logic [7:0] SEG_A   = 8'h88;
    localparam logic [7:0] SEG_B   = 8'h83;
    localparam logic [7:0] SEG_C   = 8'hC6;
    localparam logic [7:0] SEG_D   = 8'hA1;
    localparam logic [7:0] SEG_E   = 8'h86;
    localparam logic [7:0] SEG_F   = 8'h8E;
    localparam logic [7:0] SEG_OFF = 8'hFF;

    localparam logic [15:0][7:0] SEG_LUT = {SEG_F, SEG_E, SEG_D, SEG_C, SEG_B, SEG_A, SEG_9, SEG_8,
                                            SEG_7, SEG_6, SEG_5, SEG_4, SEG_3, SEG_2, SEG_1, SEG_0};

    typedef enum logic {GHOST_RUN, GHOST_BLANK} ghost_state_e;

    // A digit enable is usable only when exactly one bit is pulled low.
    function automatic logic one_low(input logic [NUM_DIGITS-1:0] en);
        return $countones(~en) == 1;
    endfunction

endpackage

// File: rtl/seg_display_driver_seg7_decode.sv
// seg7_decode: {dp, hex} to active-low {dp,g,f,e,d,c,b,a} segment pattern.
module seg7_decode
    import seg_display_driver_pkg::*;
(
    input  logic       dp,
    input  logic [3:0] hex,
    output logic [7:0] seg
);

    always_comb begin
        seg         = SEG_LUT[hex];
        seg[DP_BIT] = ~dp & seg[DP_BIT];
    end

endmodule

// File: rtl/seg_display_driver.sv
// seg_display_driver: scans an 8-digit register file onto the segment bus with blank, blink
// and post-switch ghost suppression; led_en_out and seg_out are registered and cycle-aligned.
module seg_display_driver
    import seg_display_driver_pkg::*;
#(
    parameter int unsigned BLINK_CYCLES = 50_000_000,
    parameter int unsigned GHOST_CYCLES = 16
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] led_en_in,
    input  logic       wr_en,
    input  logic [2:0] wr_addr,
    input  logic [4:0] wr_data,
    input  logic [7:0] blank_mask,
    input  logic [7:0] blink_mask,
    output logic [7:0] led_en_out,
    output logic [7:0] seg_out
);

    localparam int GW = GHOST_CYCLES > 1 ? $clog2(GHOST_CYCLES) : 1;
    localparam int BW = BLINK_CYCLES > 1 ? $clog2(BLINK_CYCLES) : 1;

    logic [4:0]    digit_q [NUM_DIGITS];
    logic [4:0]    digit_d [NUM_DIGITS];
    logic [7:0]    led_en_q, led_en_d;
    logic [7:0]    led_prev_q, led_prev_d;
    logic [7:0]    led_en_out_q, led_en_out_d;
    logic [7:0]    seg_out_q, seg_out_d;
    ghost_state_e  ghost_q, ghost_d;
    logic [GW-1:0] ghost_cnt_q, ghost_cnt_d;
    logic [BW-1:0] blink_cnt_q, blink_cnt_d;
    logic          blink_on_q, blink_on_d;
    logic          valid, changed, blink_wrap;
    logic [2:0]    idx;
    logic [4:0]    cur_digit;
    logic [7:0]    dec_seg;

    assign cur_digit = digit_q[idx];

    seg7_decode u_dec (
        .dp  (cur_digit[4]),
        .hex (cur_digit[3:0]),
        .seg (dec_seg)
    );

    always_comb begin
        digit_d = digit_q;
        if (wr_en) digit_d[wr_addr] = wr_data;
        led_en_d   = led_en_in;
        led_prev_d = led_en_q;
        valid      = one_low(led_en_q);
        changed    = led_en_q != led_prev_q;
        idx        = '0;
        for (int i = 0; i < NUM_DIGITS; i++)
            if (!led_en_q[i]) idx = 3'(i);
        // Any change of the enable pattern (re)starts the ghost window, even mid-window.
        ghost_d     = changed ? GHOST_BLANK
                    : (ghost_q == GHOST_BLANK && ghost_cnt_q == '0) ? GHOST_RUN : ghost_q;
        ghost_cnt_d = changed ? GW'(GHOST_CYCLES - 1)
                    : (ghost_q == GHOST_BLANK && ghost_cnt_q != '0) ? ghost_cnt_q - 1'b1 : ghost_cnt_q;
        blink_wrap  = blink_cnt_q == BW'(BLINK_CYCLES - 1);
        blink_cnt_d = blink_wrap ? '0 : blink_cnt_q + 1'b1;
        blink_on_d  = blink_on_q ^ blink_wrap;
        // Blank from the same edge that moves led_en_out, so no segment of the old digit leaks.
        seg_out_d    = !valid                           ? SEG_OFF
                     : ghost_d == GHOST_BLANK           ? SEG_OFF
                     : blank_mask[idx]                  ? SEG_OFF
                     : (!blink_on_q && blink_mask[idx]) ? SEG_OFF
                     : dec_seg;
        led_en_out_d = valid ? led_en_q : 8'hFF;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) digit_q[i] <= '0;
            led_en_q     <= 8'hFF;
            led_prev_q   <= 8'hFF;
            led_en_out_q <= 8'hFF;
            seg_out_q    <= SEG_OFF;
            ghost_q      <= GHOST_BLANK;
            ghost_cnt_q  <= GW'(GHOST_CYCLES - 1);
            blink_cnt_q  <= '0;
            blink_on_q   <= 1'b1;
        end else begin
            digit_q      <= digit_d;
            led_en_q     <= led_en_d;
            led_prev_q   <= led_prev_d;
            led_en_out_q <= led_en_out_d;
            seg_out_q    <= seg_out_d;
            ghost_q      <= ghost_d;
            ghost_cnt_q  <= ghost_cnt_d;
            blink_cnt_q  <= blink_cnt_d;
            blink_on_q   <= blink_on_d;
        end
    end

    assign led_en_out = led_en_out_q;
    assign seg_out    = seg_out_q;

endmodule

// File: tb/tb_seg_display_driver.sv
// tb_seg_display_driver: scoreboard bench; a cycle-count model queues expected outputs per edge.
module tb_seg_display_driver;

    localparam int B = 20;
    localparam int G = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] led_en_in;
    logic       wr_en;
    logic [2:0] wr_addr;
    logic [4:0] wr_data;
    logic [7:0] blank_mask;
    logic [7:0] blink_mask;
    logic [7:0] led_en_out;
    logic [7:0] seg_out;

    int n_chk = 0;
    int n_bad = 0;

    seg_display_driver #(.BLINK_CYCLES(B), .GHOST_CYCLES(G)) dut (
        .clk        (clk),
        .rst        (rst),
        .led_en_in  (led_en_in),
        .wr_en      (wr_en),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .blank_mask (blank_mask),
        .blink_mask (blink_mask),
        .led_en_out (led_en_out),
        .seg_out    (seg_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [7:0] got, input logic [7:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %02h expected %02h at %0t", tag, got, exp, $time);
        end
    endtask

    logic [7:0] tbl [16] = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                             8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};

    // Model state: enable history, edges since the last enable change, edges since reset.
    logic [7:0]  m_len, m_prev;
    logic [4:0]  m_dig [8];
    int          m_since, m_k;
    logic [15:0] sb [$];
    logic [15:0] sb_e;

    function automatic logic [7:0] dec(input logic [4:0] d);
        logic [7:0] s;
        s = tbl[d[3:0]];
        return d[4] ? {1'b0, s[6:0]} : s;
    endfunction

    function automatic logic [15:0] model_out(input logic [7:0] len, input int since_n, input int k,
                                              input logic [7:0] bl, input logic [7:0] bk);
        int sel = 0;
        int zeros = 0;
        for (int i = 0; i < 8; i++)
            if (!len[i]) begin
                zeros++;
                sel = i;
            end
        if (zeros != 1) return 16'hFFFF;
        if (since_n < G || bl[sel] || (((k / B) % 2) == 1 && bk[sel])) return {len, 8'hFF};
        return {len, dec(m_dig[sel])};
    endfunction

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            m_len   <= 8'hFF;
            m_prev  <= 8'hFF;
            m_since <= 0;
            m_k     <= 0;
            for (int i = 0; i < 8; i++) m_dig[i] <= '0;
            sb.delete();
        end else begin
            sb.push_back(model_out(m_len, (m_len != m_prev) ? 0 : m_since + 1, m_k, blank_mask, blink_mask));
            m_since <= (m_len != m_prev) ? 0 : m_since + 1;
            m_prev  <= m_len;
            m_len   <= led_en_in;
            m_k     <= m_k + 1;
            if (wr_en) m_dig[wr_addr] <= wr_data;
        end
    end

    always @(negedge clk) begin
        if (rst) begin
            chk("rst_led", led_en_out, 8'hFF);
            chk("rst_seg", seg_out, 8'hFF);
        end else if (sb.size() > 0) begin
            sb_e = sb.pop_front();
            chk("sb_led", led_en_out, sb_e[15:8]);
            chk("sb_seg", seg_out, sb_e[7:0]);
        end
    end

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic wr(input logic [2:0] a, input logic [4:0] d);
        wr_en   = 1'b1;
        wr_addr = a;
        wr_data = d;
        tick(1);
        wr_en   = 1'b0;
    endtask

    task automatic count_off(input int n, output int c);
        c = 0;
        repeat (n) begin
            @(negedge clk);
            if (seg_out == 8'hFF) c++;
        end
    endtask

    int c;

    initial begin
        rst = 1'b1;
        led_en_in = 8'hFE;
        wr_en = 1'b0;
        wr_addr = '0;
        wr_data = '0;
        blank_mask = '0;
        blink_mask = '0;
        tick(3);
        rst = 1'b0;
        tick(10);
        chk("t1_seg", seg_out, 8'hC0);
        chk("t1_led", led_en_out, 8'hFE);

        wr(3'd3, 5'h18);
        led_en_in = 8'hF7;
        tick(10);
        chk("t2_seg", seg_out, 8'h00);
        chk("t2_led", led_en_out, 8'hF7);

        wr(3'd1, 5'h02);
        for (int i = 0; i < 4; i++) begin
            led_en_in = (i % 2 == 0) ? 8'hFE : 8'hFD;
            count_off(10, c);
            chk("t3_ghost_len", 8'(c), 8'd4);
        end
        chk("t3_seg", seg_out, 8'hA4);

        wr(3'd0, 5'h05);
        led_en_in  = 8'hFE;
        blink_mask = 8'h01;
        tick(10);
        count_off(40, c);
        chk("t4_blink_off", 8'(c), 8'd20);
        blank_mask = 8'h01;
        count_off(25, c);
        chk("t4_blank_off", 8'(c), 8'd25);

        blank_mask = '0;
        blink_mask = '0;
        led_en_in  = 8'hFC;
        tick(3);
        chk("t5_multi_seg", seg_out, 8'hFF);
        chk("t5_multi_led", led_en_out, 8'hFF);
        led_en_in = 8'hFF;
        tick(3);
        chk("t5_none_seg", seg_out, 8'hFF);
        chk("t5_none_led", led_en_out, 8'hFF);

        led_en_in = 8'hFE;
        tick(8);
        led_en_in = 8'hFD;
        tick(2);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_arst_led", led_en_out, 8'hFF);
        chk("t6_arst_seg", seg_out, 8'hFF);
        tick(3);
        rst = 1'b0;
        tick(10);
        chk("t6_rec_seg", seg_out, 8'hC0);
        chk("t6_rec_led", led_en_out, 8'hFD);

        blink_mask = 8'hFF;
        tick(27);
        @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("t6_blink_rst_seg", seg_out, 8'hFF);
        tick(2);
        rst = 1'b0;
        tick(3);
        chk("t6_ghost_seg", seg_out, 8'hFF);
        tick(7);
        chk("t6_rec2_seg", seg_out, 8'hC0);
        chk("t6_rec2_led", led_en_out, 8'hFD);
        tick(2);

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
